// File: rtl/falling_write_fifo.sv
// Show-ahead FIFO: pushes land on the falling clock edge, pops retire on the rising edge,
// so a rising-edge consumer sees freshly written data half a cycle after the push.
module falling_write_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   // Occupancy derives from the two single-edge pointers; no counter is shared across edges.
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

   // Write side: falling edge
   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         wptr     <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         if (!full) begin
            mem[wptr[AW-1:0]] <= wr_data;
            wptr              <= wptr + 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end
   end

   // Read side: rising edge
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rptr      <= '0;
         underflow <= 1'b0;
      end else if (rd_en) begin
         if (!empty) rptr <= rptr + 1'b1;
         else        underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_falling_write_fifo.sv
// Directed bench for falling_write_fifo: negedge pushes, posedge pops, DEPTH=4.
module tb_falling_write_fifo;

   logic        clk = 1'b0;
   logic        clr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        full;
   logic        empty;
   logic [2:0]  count;
   logic        overflow;
   logic        underflow;

   int tests = 0;
   int fails = 0;

   falling_write_fifo #(.WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .full(full), .empty(empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Push lands at the next negedge; returns 1 time unit after it.
   task automatic push(input logic [31:0] d);
      wr_en = 1'b1; wr_data = d;
      @(negedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Pop lands at the next posedge; returns 1 time unit after it.
   task automatic pop();
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 6; i++) begin
         if (i[0]) @(posedge clk); else @(negedge clk);
         #1;
         tests++;
         if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 32'h0 ||
             overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL reset[%0d]: count=%0d empty=%b full=%b rd_data=%h ovf=%b unf=%b, want 0 1 0 0 0 0",
                     i, count, empty, full, rd_data, overflow, underflow);
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
      clr = 1'b0;
   endtask

   task automatic test_latency();
      push(32'hA5A5_0001);
      tests++;
      if (empty !== 1'b0 || rd_data !== 32'hA5A5_0001) begin
         fails++;
         $display("FAIL latency_push: empty=%b rd_data=%h, want 0 a5a50001", empty, rd_data);
      end
      pop();
      tests++;
      if (empty !== 1'b1 || rd_data !== 32'h0 || underflow !== 1'b0) begin
         fails++;
         $display("FAIL latency_pop: empty=%b rd_data=%h unf=%b, want 1 0 0", empty, rd_data, underflow);
      end
   endtask

   task automatic test_fill_overflow();
      logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) push(exp[i]);
      tests++;
      if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL fill: full=%b count=%0d ovf=%b, want 1 4 0", full, count, overflow);
      end
      push(32'h55);
      tests++;
      if (overflow !== 1'b1 || count !== 3'd4 || rd_data !== 32'h11) begin
         fails++;
         $display("FAIL overflow: ovf=%b count=%0d rd_data=%h, want 1 4 11", overflow, count, rd_data);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (rd_data !== exp[i]) begin
            fails++;
            $display("FAIL drain[%0d]: rd_data=%h, want %h", i, rd_data, exp[i]);
         end
         pop();
      end
      tests++;
      if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 32'h0) begin
         fails++;
         $display("FAIL drained: empty=%b count=%0d rd_data=%h, want 1 0 0", empty, count, rd_data);
      end
   endtask

   task automatic test_full_boundary();
      logic [31:0] exp [4] = '{32'h22, 32'h33, 32'h44, 32'h66};
      push(32'h11); push(32'h22); push(32'h33); push(32'h44);
      pop();
      tests++;
      if (full !== 1'b0 || count !== 3'd3 || rd_data !== 32'h22) begin
         fails++;
         $display("FAIL boundary_pop: full=%b count=%0d rd_data=%h, want 0 3 22", full, count, rd_data);
      end
      push(32'h66);
      tests++;
      if (full !== 1'b1 || count !== 3'd4) begin
         fails++;
         $display("FAIL boundary_push: full=%b count=%0d, want 1 4", full, count);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (rd_data !== exp[i]) begin
            fails++;
            $display("FAIL boundary_drain[%0d]: rd_data=%h, want %h", i, rd_data, exp[i]);
         end
         pop();
      end
   endtask

   task automatic test_wrap_underflow();
      for (int i = 1; i <= 10; i++) begin
         wr_en = 1'b1; wr_data = i; rd_en = 1'b1;
         @(negedge clk); #1;
         wr_en = 1'b0;
         tests++;
         if (rd_data !== 32'(i) || count !== 3'd1) begin
            fails++;
            $display("FAIL wrap_push[%0d]: rd_data=%h count=%0d, want %h 1", i, rd_data, count, i);
         end
         @(posedge clk); #1;
         rd_en = 1'b0;
         tests++;
         if (count !== 3'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pop[%0d]: count=%0d empty=%b unf=%b, want 0 1 0", i, count, empty, underflow);
         end
      end
      pop();
      tests++;
      if (underflow !== 1'b1 || count !== 3'd0) begin
         fails++;
         $display("FAIL underflow: unf=%b count=%0d, want 1 0", underflow, count);
      end
      push(32'h99);
      pop();
      tests++;
      if (underflow !== 1'b1 || empty !== 1'b1) begin
         fails++;
         $display("FAIL underflow_sticky: unf=%b empty=%b, want 1 1", underflow, empty);
      end
   endtask

   task automatic test_mid_reset();
      push(32'hC1); push(32'hC2); push(32'hC3);
      tests++;
      if (count !== 3'd3 || rd_data !== 32'hC1) begin
         fails++;
         $display("FAIL pre_reset: count=%0d rd_data=%h, want 3 c1", count, rd_data);
      end
      #1 clr = 1'b1;
      #1;
      tests++;
      if (count !== 3'd0 || rd_data !== 32'h0 || empty !== 1'b1 || full !== 1'b0 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: count=%0d rd_data=%h empty=%b full=%b ovf=%b unf=%b, want 0 0 1 0 0 0",
                  count, rd_data, empty, full, overflow, underflow);
      end
      clr = 1'b0;
      push(32'h77);
      tests++;
      if (rd_data !== 32'h77 || count !== 3'd1) begin
         fails++;
         $display("FAIL post_reset: rd_data=%h count=%0d, want 77 1", rd_data, count);
      end
   endtask

   initial begin
      clr = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      test_reset();
      test_latency();
      test_fill_overflow();
      test_full_boundary();
      test_wrap_underflow();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
